// File: rtl/regfile_wb_sched.sv
// rtl/regfile_wb_sched.sv - ALU/LSU writeback arbiter, register-file write stage and busy scoreboard
// Optional: define RR_ARB_EN for round-robin arbitration; default is fixed LSU priority.
module regfile_wb_sched #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             alu_valid,
    input  logic [4:0]       alu_rd,
    input  logic [31:0]      alu_wd,
    output logic             alu_ready,
    input  logic             lsu_valid,
    input  logic [4:0]       lsu_rd,
    input  logic [31:0]      lsu_wd,
    output logic             lsu_ready,
    output logic             rf_we,
    output logic [4:0]       rf_wa,
    output logic [31:0]      rf_wd,
    input  logic             iss_valid,
    input  logic [4:0]       iss_rd,
    input  logic [4:0]       chk_a1,
    input  logic [4:0]       chk_a2,
    output logic             hazard,
    output logic [31:0]      busy,
    output logic [CNT_W-1:0] stall_cnt
);

    logic        alu_wins;
    logic        accept;
    logic [4:0]  acc_rd;
    logic [31:0] acc_wd;
    logic        stall_now;
    logic [31:0] set_vec;
    logic [31:0] clr_vec;
    logic [31:0] busy_next;

`ifdef RR_ARB_EN
    // High when the LSU took the most recent grant; ALU goes first after reset.
    logic last_lsu;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_lsu <= 1'b1;
        end else if (alu_ready) begin
            last_lsu <= 1'b0;
        end else if (lsu_ready) begin
            last_lsu <= 1'b1;
        end
    end

    assign alu_wins = last_lsu;
`else
    assign alu_wins = 1'b0;
`endif

    always_comb begin
        alu_ready = alu_valid & (~lsu_valid | alu_wins);
        lsu_ready = lsu_valid & ~alu_ready;
        accept    = alu_ready | lsu_ready;
        acc_rd    = alu_ready ? alu_rd : lsu_rd;
        acc_wd    = alu_ready ? alu_wd : lsu_wd;
        stall_now = (alu_valid & ~alu_ready) | (lsu_valid & ~lsu_ready);
    end

    // Single output register: drains every cycle, so it never back-pressures.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rf_we <= 1'b0;
            rf_wa <= 5'd0;
            rf_wd <= 32'd0;
        end else if (accept) begin
            rf_we <= (acc_rd != 5'd0);
            rf_wa <= acc_rd;
            rf_wd <= acc_wd;
        end else begin
            rf_we <= 1'b0;
        end
    end

    // Set is applied after clear so a fresh issue survives a same-cycle writeback.
    always_comb begin
        set_vec   = (iss_valid && iss_rd != 5'd0) ? (32'd1 << iss_rd) : 32'd0;
        clr_vec   = rf_we ? (32'd1 << rf_wa) : 32'd0;
        busy_next = (busy & ~clr_vec) | set_vec;
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy <= 32'd0;
        end else begin
            busy <= busy_next;
        end
    end

    assign hazard = busy[chk_a1] | busy[chk_a2];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (stall_now && stall_cnt != {CNT_W{1'b1}}) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_regfile_wb_sched.sv
// tb/tb_regfile_wb_sched.sv - scoreboard bench for regfile_wb_sched
module tb_regfile_wb_sched;

    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic             clk = 1'b0;
    logic             rst_n;
    logic             alu_valid, lsu_valid, iss_valid;
    logic [4:0]       alu_rd, lsu_rd, iss_rd, chk_a1, chk_a2;
    logic [31:0]      alu_wd, lsu_wd;
    logic             alu_ready, lsu_ready, rf_we, hazard;
    logic [4:0]       rf_wa;
    logic [31:0]      rf_wd, busy;
    logic [CNT_W-1:0] stall_cnt;

    regfile_wb_sched #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_wd(alu_wd), .alu_ready(alu_ready),
        .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_wd(lsu_wd), .lsu_ready(lsu_ready),
        .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .chk_a1(chk_a1), .chk_a2(chk_a2),
        .hazard(hazard), .busy(busy), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
    } wr_t;

    wr_t exp_q[$];

    int checks = 0;
    int errors = 0;

    logic             m_last_lsu = 1'b1;
    logic [31:0]      m_busy = 32'd0;
    logic [CNT_W-1:0] m_stall = '0;
    wr_t              m_out = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Called #1 after a posedge with inputs already driven; ends #1 after the next posedge.
    task automatic step();
        logic  ga, gl;
        wr_t   nxt, got;
        logic [31:0] nb;
        #1;
`ifdef RR_ARB_EN
        ga = alu_valid & (~lsu_valid | m_last_lsu);
`else
        ga = alu_valid & ~lsu_valid;
`endif
        gl = lsu_valid & ~ga;
        check("alu_ready", alu_ready, ga);
        check("lsu_ready", lsu_ready, gl);
        check("hazard", hazard, m_busy[chk_a1] | m_busy[chk_a2]);

        if (!rst_n)  nxt = '0;
        else if (ga) nxt = '{we: alu_rd != 0, wa: alu_rd, wd: alu_wd};
        else if (gl) nxt = '{we: lsu_rd != 0, wa: lsu_rd, wd: lsu_wd};
        else         nxt = '{we: 1'b0, wa: m_out.wa, wd: m_out.wd};
        exp_q.push_back(nxt);

        nb = m_busy;
        if (m_out.we) nb[m_out.wa] = 1'b0;
        if (iss_valid) nb[iss_rd] = 1'b1;
        nb[0] = 1'b0;

        @(posedge clk);
        #1;
        if (!rst_n) begin
            m_busy = '0;
            m_stall = '0;
            m_last_lsu = 1'b1;
        end else begin
            m_busy = nb;
            if (((alu_valid & ~ga) | (lsu_valid & ~gl)) && m_stall != CNT_MAX) m_stall = m_stall + 1'b1;
            if (ga) m_last_lsu = 1'b0;
            else if (gl) m_last_lsu = 1'b1;
        end

        if (exp_q.size() == 0) begin
            check("queue_empty", 1, 0);
        end else begin
            got = '{we: rf_we, wa: rf_wa, wd: rf_wd};
            nxt = exp_q.pop_front();
            check("rf_we", got.we, nxt.we);
            check("rf_wa", got.wa, nxt.wa);
            check("rf_wd", got.wd, nxt.wd);
            m_out = nxt;
        end
        check("busy", busy, m_busy);
        check("stall_cnt", stall_cnt, m_stall);
    endtask

    task automatic idle();
        alu_valid = 0; lsu_valid = 0; iss_valid = 0;
    endtask

    initial begin
        rst_n = 0; iss_valid = 0; iss_rd = 0; chk_a1 = 0; chk_a2 = 0;
        alu_valid = 1; alu_rd = 1; alu_wd = 32'h1111_0001;
        lsu_valid = 1; lsu_rd = 2; lsu_wd = 32'h2222_0002;
        @(posedge clk); #1;

        // Reset held two cycles with both requesters active
        repeat (2) step();
        check("rst_we", rf_we, 0);
        check("rst_busy", busy, 0);
        check("rst_stall", stall_cnt, 0);

        // First ALU write after reset lands one cycle later
        rst_n = 1; idle();
        alu_valid = 1; alu_rd = 5; alu_wd = 32'hDEAD_BEEF;
        step();
        check("first_wa", rf_wa, 5);
        check("first_wd", rf_wd, 32'hDEAD_BEEF);
        idle(); step();

        // Four-cycle conflict
        alu_valid = 1; alu_rd = 1; alu_wd = 32'h0000_0111;
        lsu_valid = 1; lsu_rd = 2; lsu_wd = 32'h0000_0222;
        repeat (4) step();
        check("conflict_stall", stall_cnt, 4);
        idle(); step();

        // Scoreboard set, hazard, clear on writeback
        iss_valid = 1; iss_rd = 7; step();
        iss_valid = 0; chk_a1 = 7; step();
        check("busy7_set", busy[7], 1);
        lsu_valid = 1; lsu_rd = 7; lsu_wd = 32'h7777_7777; step();
        idle(); step();
        check("busy7_clr", busy[7], 0);
        chk_a1 = 0;

        // Set and clear collide on x9
        iss_valid = 1; iss_rd = 9; step();
        iss_valid = 0; lsu_valid = 1; lsu_rd = 9; lsu_wd = 32'h9999_0009; step();
        lsu_valid = 0; iss_valid = 1; iss_rd = 9; step();
        check("busy9_keep", busy[9], 1);
        idle(); step();

        // x0 writes and issues
        alu_valid = 1; alu_rd = 0; alu_wd = 32'h0BAD_0000; step();
        check("x0_we", rf_we, 0);
        idle(); iss_valid = 1; iss_rd = 0; step();
        iss_valid = 0; chk_a1 = 0; chk_a2 = 0; step();
        check("x0_busy0", busy[0], 0);

        // Stall counter saturation
        alu_valid = 1; alu_rd = 3; alu_wd = 32'h3;
        lsu_valid = 1; lsu_rd = 4; lsu_wd = 32'h4;
        repeat (20) step();
        check("stall_sat", stall_cnt, 15);
        idle(); step();

        // Random traffic
        for (int i = 0; i < 60; i++) begin
            alu_valid = 1'($urandom_range(0, 1)); alu_rd = 5'($urandom); alu_wd = $urandom;
            lsu_valid = 1'($urandom_range(0, 1)); lsu_rd = 5'($urandom); lsu_wd = $urandom;
            iss_valid = 1'($urandom_range(0, 1)); iss_rd = 5'($urandom);
            chk_a1 = 5'($urandom); chk_a2 = 5'($urandom);
            step();
        end

        // Reset mid-transfer discards the in-flight write
        idle(); alu_valid = 1; alu_rd = 12; alu_wd = 32'hC0DE_000C; step();
        rst_n = 0; step();
        check("midrst_we", rf_we, 0);
        check("midrst_wd", rf_wd, 0);
        rst_n = 1; idle(); step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
